dbg_sba_arbiter: RTL and testbench

DBG_SBA_ARBITER -- requirements
Module: dbg_sba_arbiter

---
 rtl/dbg_sba_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dbg_sba_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dbg_sba_arbiter.sv
// -----------------------------------------------------------------------------
// dbg_sba_arbiter
//
// Shares one downstream memory port between the core data port and the debug
// module's system-bus-access host. Arbitration is round-robin on ties. Once
// a request has been put on the bus and not yet granted, that owner is held
// until the grant arrives. Response ownership is tracked in an in-order FIFO
// so that each bus_rvalid_i is routed back to whoever issued the request.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   core_req_i/addr/we/be/wdata       core request (held until granted)
//   core_gnt_o, core_rvalid_o         core grant / response strobe
//   dm_req_i/addr/we/be/wdata         debug-module request (held until granted)
//   dm_gnt_o, dm_rvalid_o             debug-module grant / response strobe
//   bus_req_o/addr/we/be/wdata        downstream request
//   bus_gnt_i, bus_rvalid_i           downstream grant / in-order response
//   err_o                             sticky: response with nothing outstanding
// -----------------------------------------------------------------------------
module dbg_sba_arbiter #(
    parameter int BusWidth       = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  core_req_i,
    input  logic [BusWidth-1:0]   core_addr_i,
    input  logic                  core_we_i,
    input  logic [BusWidth/8-1:0] core_be_i,
    input  logic [BusWidth-1:0]   core_wdata_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    input  logic                  dm_req_i,
    input  logic [BusWidth-1:0]   dm_addr_i,
    input  logic                  dm_we_i,
    input  logic [BusWidth/8-1:0] dm_be_i,
    input  logic [BusWidth-1:0]   dm_wdata_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rvalid_o,
    output logic                  bus_req_o,
    output logic [BusWidth-1:0]   bus_addr_o,
    output logic                  bus_we_o,
    output logic [BusWidth/8-1:0] bus_be_o,
    output logic [BusWidth-1:0]   bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    output logic                  err_o
);

    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic                  own_reg, own_next;     // 0 = core, 1 = DM
    logic                  last_reg, last_next;   // last granted owner
    logic [PtrW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CntW-1:0]       count_reg;
    logic                  err_reg;
    logic [MaxOutstanding-1:0] fifo_owner;

    logic sel;        // selected requester (0 = core, 1 = DM)
    logic sel_req;    // selected requester is actually requesting
    logic fifo_full;
    logic fifo_empty;
    logic grant;
    logic pop;
    logic head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Requester selection. A pending HOLD pins the owner even if the other
    // side starts requesting; otherwise ties go to whoever was not last.
    always_comb begin
        sel     = 1'b0;
        sel_req = 1'b0;
        if (state_reg == HOLD) begin
            sel     = own_reg;
            sel_req = own_reg ? dm_req_i : core_req_i;
        end else if (core_req_i && dm_req_i) begin
            sel     = ~last_reg;
            sel_req = 1'b1;
        end else if (core_req_i) begin
            sel     = 1'b0;
            sel_req = 1'b1;
        end else if (dm_req_i) begin
            sel     = 1'b1;
            sel_req = 1'b1;
        end
    end

    assign fifo_full  = (count_reg == CntW'(MaxOutstanding));
    assign fifo_empty = (count_reg == '0);

    // Full uses the pre-pop count: no grant while full, even if a response
    // frees a slot in the same cycle.
    assign bus_req_o   = sel_req & ~fifo_full & ~rst_i;
    assign grant       = bus_req_o & bus_gnt_i;
    assign core_gnt_o  = grant & ~sel;
    assign dm_gnt_o    = grant & sel;

    assign bus_addr_o  = sel ? dm_addr_i  : core_addr_i;
    assign bus_we_o    = sel ? dm_we_i    : core_we_i;
    assign bus_be_o    = sel ? dm_be_i    : core_be_i;
    assign bus_wdata_o = sel ? dm_wdata_i : core_wdata_i;

    assign head          = fifo_owner[rd_ptr_reg];
    assign pop           = bus_rvalid_i & ~fifo_empty & ~rst_i;
    assign core_rvalid_o = pop & ~head;
    assign dm_rvalid_o   = pop & head;
    assign err_o         = err_reg;

    // Owner FIFO storage, one flop per slot.
    for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_entry
        logic owner_reg;
        always_ff @(posedge clk_i) begin
            if (grant && (wr_ptr_reg == PtrW'(gi))) begin
                owner_reg <= sel;
            end
        end
        assign fifo_owner[gi] = owner_reg;
    end

    // Next-state logic. A requester that withdraws while held (protocol
    // violation) simply drops sel_req, which returns us to ARB.
    always_comb begin
        state_next = state_reg;
        own_next   = own_reg;
        last_next  = last_reg;
        case (state_reg)
            ARB: begin
                if (bus_req_o && !grant) begin
                    state_next = HOLD;
                    own_next   = sel;
                end
            end
            HOLD: begin
                if (grant || !sel_req) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
        if (grant) begin
            last_next = sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ARB;
            own_reg    <= 1'b0;
            last_reg   <= 1'b1;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            own_reg   <= own_next;
            last_reg  <= last_next;
            if (grant) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({grant, pop})
                2'b10:   count_reg <= count_reg + CntW'(1);
                2'b01:   count_reg <= count_reg - CntW'(1);
                default: count_reg <= count_reg;
            endcase
            if (bus_rvalid_i && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dbg_sba_arbiter.sv
module tb_dbg_sba_arbiter;

    localparam int BW = 32;
    localparam int MO = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_req = 1'b0;
    logic [BW-1:0] core_addr = '0;
    logic          core_we = 1'b0;
    logic [3:0]    core_be = '0;
    logic [BW-1:0] core_wdata = '0;
    logic          core_gnt, core_rvalid;
    logic          dm_req = 1'b0;
    logic [BW-1:0] dm_addr = '0;
    logic          dm_we = 1'b0;
    logic [3:0]    dm_be = '0;
    logic [BW-1:0] dm_wdata = '0;
    logic          dm_gnt, dm_rvalid;
    logic          bus_req;
    logic [BW-1:0] bus_addr;
    logic          bus_we;
    logic [3:0]    bus_be;
    logic [BW-1:0] bus_wdata;
    logic          bus_gnt = 1'b0;
    logic          bus_rvalid = 1'b0;
    logic          err;

    dbg_sba_arbiter #(.BusWidth(BW), .MaxOutstanding(MO)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(core_req), .core_addr_i(core_addr), .core_we_i(core_we),
        .core_be_i(core_be), .core_wdata_i(core_wdata),
        .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
        .dm_req_i(dm_req), .dm_addr_i(dm_addr), .dm_we_i(dm_we),
        .dm_be_i(dm_be), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid),
        .bus_req_o(bus_req), .bus_addr_o(bus_addr), .bus_we_o(bus_we),
        .bus_be_o(bus_be), .bus_wdata_o(bus_wdata),
        .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid),
        .err_o(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: queue of owners awaiting a response, the owner pinned
    // by an ungranted presented request (-1 none), the last granted owner
    // (0 core, 1 DM) and the sticky error flag.
    int q[$];
    int hold_own = -1;
    int last_own = 1;
    bit err_m    = 1'b0;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // then advance the model across the rising edge.
    task automatic step(input bit cr, input bit dr, input bit g, input bit rv, input bit rs,
                        output bit cg, output bit dg);
        int sel;
        int head;
        bit selreq, breq, gr, full, empty, popv;
        rst        = rs;
        core_req   = cr;
        dm_req     = dr;
        bus_gnt    = g;
        bus_rvalid = rv;
        core_addr  = $urandom; core_wdata = $urandom;
        core_we    = 1'($urandom_range(0, 1)); core_be = 4'($urandom);
        dm_addr    = $urandom; dm_wdata = $urandom;
        dm_we      = 1'($urandom_range(0, 1)); dm_be = 4'($urandom);
        #1;
        full   = (q.size() == MO);
        empty  = (q.size() == 0);
        sel    = 0;
        selreq = 1'b0;
        if (hold_own >= 0) begin
            sel    = hold_own;
            selreq = (sel == 1) ? dr : cr;
        end else if (cr && dr) begin
            sel    = 1 - last_own;
            selreq = 1'b1;
        end else if (cr) begin
            sel    = 0;
            selreq = 1'b1;
        end else if (dr) begin
            sel    = 1;
            selreq = 1'b1;
        end
        breq = !rs && selreq && !full;
        gr   = breq && g;
        popv = !rs && rv && !empty;
        head = empty ? 0 : q[0];

        check("bus_req", BW'(bus_req), BW'(breq));
        check("core_gnt", BW'(core_gnt), BW'(gr && sel == 0));
        check("dm_gnt", BW'(dm_gnt), BW'(gr && sel == 1));
        check("core_rvalid", BW'(core_rvalid), BW'(popv && head == 0));
        check("dm_rvalid", BW'(dm_rvalid), BW'(popv && head == 1));
        check("err", BW'(err), BW'(err_m));
        if (breq) begin
            check("bus_addr", bus_addr, (sel == 1) ? dm_addr : core_addr);
            check("bus_we", BW'(bus_we), BW'((sel == 1) ? dm_we : core_we));
            check("bus_be", BW'(bus_be), BW'((sel == 1) ? dm_be : core_be));
            check("bus_wdata", bus_wdata, (sel == 1) ? dm_wdata : core_wdata);
        end
        if (gr || popv || rs)
            $display("cycle %0d rst=%0b req=%0b%0b gnt=%0b(%s) rvalid=%0b(%s) outstanding=%0d err=%0b",
                     cycle, rs, cr, dr, gr, (sel == 1) ? "dm" : "core",
                     popv, (head == 1) ? "dm" : "core", q.size(), err_m);
        cg = gr && sel == 0;
        dg = gr && sel == 1;

        @(posedge clk);
        cycle++;
        if (rs) begin
            q.delete();
            hold_own = -1;
            last_own = 1;
            err_m    = 1'b0;
        end else begin
            if (rv && empty) err_m = 1'b1;
            if (popv) void'(q.pop_front());
            if (gr) begin
                q.push_back(sel);
                last_own = sel;
                hold_own = -1;
            end else if (hold_own >= 0) begin
                if (!selreq) hold_own = -1;
            end else if (breq) begin
                hold_own = sel;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit cg, dg;
        bit cr_act, dr_act;
        @(negedge clk);
        // Reset state
        step(0, 0, 0, 0, 1, cg, dg);
        step(1, 1, 1, 1, 1, cg, dg);
        // Core read, response two cycles later
        step(1, 0, 1, 0, 0, cg, dg);
        step(0, 0, 1, 0, 0, cg, dg);
        step(0, 0, 1, 1, 0, cg, dg);
        // Tie from reset: core, DM, then stall on full; in-order responses
        step(0, 0, 0, 0, 1, cg, dg);
        step(1, 1, 1, 0, 0, cg, dg);
        step(1, 1, 1, 0, 0, cg, dg);
        step(1, 1, 1, 0, 0, cg, dg);
        step(1, 1, 1, 1, 0, cg, dg);
        step(1, 1, 1, 1, 0, cg, dg);
        step(0, 1, 1, 1, 0, cg, dg);
        step(0, 0, 0, 1, 0, cg, dg);
        // Stray response sets sticky error
        step(0, 0, 0, 1, 0, cg, dg);
        step(0, 0, 0, 0, 0, cg, dg);
        step(1, 0, 1, 0, 0, cg, dg);
        // DM held against a late core request until granted
        step(0, 0, 0, 0, 1, cg, dg);
        step(0, 1, 0, 0, 0, cg, dg);
        step(1, 1, 0, 0, 0, cg, dg);
        step(1, 1, 0, 0, 0, cg, dg);
        step(1, 1, 1, 0, 0, cg, dg);
        step(1, 0, 1, 0, 0, cg, dg);
        // Reset with two outstanding, then a late response
        step(1, 1, 1, 1, 1, cg, dg);
        step(0, 0, 0, 1, 0, cg, dg);
        step(0, 0, 0, 0, 0, cg, dg);
        // Requester withdrawing while held
        step(0, 0, 0, 0, 1, cg, dg);
        step(0, 1, 0, 0, 0, cg, dg);
        step(1, 0, 1, 0, 0, cg, dg);
        step(1, 0, 1, 0, 0, cg, dg);
        // Randomized traffic, requests held until granted
        cr_act = 1'b0;
        dr_act = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!cr_act && $urandom_range(0, 2) == 0) cr_act = 1'b1;
            if (!dr_act && $urandom_range(0, 2) == 0) dr_act = 1'b1;
            step(cr_act, dr_act, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 149) == 0, cg, dg);
            if (cg) cr_act = 1'b0;
            if (dg) dr_act = 1'b0;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
